ros2_app_data_writer: RTL and testbench

CPU-side writer for the shared ROS2 application-data buffer. It assembles a byte stream from the CPU or application logic into a shadow buffer. It then negotiates the app-data arbiter (req/grant/rel) as the CPU requester and commits the frame atomically into the `ros2_app_data` / `ros2_app_data_len` registers that the ROS2 core reads. The block sits beside `ros2_ether` and drives its `ros2_app_data*` and `ros2_app_data_cpu_*` ports.

---
 rtl/ros2_ether_pkg.sv | 24 ++
 rtl/ros2_app_data_shadow.sv | 33 +++
 rtl/ros2_app_data_writer.sv | 131 +++++++++++++
 tb/tb_ros2_app_data_writer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ros2_ether_pkg.sv
// Shared definitions for the ROS2 application-data path: writer FSM state
// encodings, default buffer size and the app-data arbiter grant encodings.
// Optional feature macro used by the writer: APP_DATA_NUL_TERM_EN.
package ros2_ether_pkg;

  // Default shadow/app-data buffer capacity in bytes.
  localparam int APP_DATA_BYTES_DEF = 64;

  // Writer FSM state encodings.
  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;

  // Arbiter grant encodings shared with the ros2_ether app-data arbiter.
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_IP   = 2'd1;
  localparam logic [1:0] GNT_CPU  = 2'd2;

  // Payload capacity: one byte is reserved for the NUL terminator when enabled.
  function automatic int app_data_capacity(input int data_bytes, input bit nul_term);
    return nul_term ? data_bytes - 1 : data_bytes;
  endfunction

endpackage

// File: rtl/ros2_app_data_shadow.sv
// Byte-addressed shadow register file for frame assembly: one byte write port,
// a whole-buffer clear and a full parallel read of every byte.
import ros2_ether_pkg::*;

module ros2_app_data_shadow #(
  parameter int DATA_BYTES = APP_DATA_BYTES_DEF,
  parameter int ADDR_W     = $clog2(DATA_BYTES)
) (
  input  logic                      clk_int,
  input  logic                      rst_int,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [7:0]                wr_data,
  input  logic                      clr,
  output logic [8*DATA_BYTES-1:0]   rd_data
);

  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_byte
    logic [7:0] byte_reg;

    // Each byte clears on reset or frame release, otherwise takes its addressed write.
    always_ff @(posedge clk_int) begin
      if (rst_int || clr) begin
        byte_reg <= 8'h00;
      end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
        byte_reg <= wr_data;
      end
    end

    assign rd_data[8*gi +: 8] = byte_reg;
  end

endmodule

// File: rtl/ros2_app_data_writer.sv
// CPU-side writer for the shared ROS2 app-data buffer. Bytes are assembled in
// a shadow buffer, then the CPU side of the app-data arbiter is requested and
// the frame is committed atomically to app_data/app_data_len on grant.
// Optional feature macro: APP_DATA_NUL_TERM_EN (reserve a byte for a NUL
// terminator and report a NUL-inclusive length).
import ros2_ether_pkg::*;

module ros2_app_data_writer #(
  parameter int DATA_BYTES = APP_DATA_BYTES_DEF,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                     clk_int,
  input  logic                     rst_int,
  input  logic [7:0]               s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic                     s_tlast,
  output logic [8*DATA_BYTES-1:0]  app_data,
  output logic [LEN_WIDTH-1:0]     app_data_len,
  output logic                     cpu_req,
  input  logic                     cpu_grant,
  output logic                     cpu_rel,
  output logic                     busy,
  output logic                     err_overflow,
  output logic [15:0]              commit_cnt
);

  localparam int ADDR_W = $clog2(DATA_BYTES);

`ifdef APP_DATA_NUL_TERM_EN
  // The shadow is cleared after each frame, so the byte at wr_ptr is already
  // 0x00 at commit; only the reported length needs to include it.
  localparam int                   CAPACITY = app_data_capacity(DATA_BYTES, 1'b1);
  localparam logic [LEN_WIDTH-1:0] NUL_LEN  = LEN_WIDTH'(1);
`else
  localparam int                   CAPACITY = app_data_capacity(DATA_BYTES, 1'b0);
  localparam logic [LEN_WIDTH-1:0] NUL_LEN  = LEN_WIDTH'(0);
`endif

  localparam logic [LEN_WIDTH-1:0] CAP_LEN = LEN_WIDTH'(CAPACITY);

  logic [1:0]               state_reg;
  logic [LEN_WIDTH-1:0]     wr_ptr_reg;
  logic                     ovf_reg;
  logic [8*DATA_BYTES-1:0]  app_data_reg;
  logic [LEN_WIDTH-1:0]     app_data_len_reg;
  logic [15:0]              commit_cnt_reg;
  logic [8*DATA_BYTES-1:0]  shadow_data;

  logic accept;
  logic room;
  logic commit;

  assign s_tready = (state_reg == ST_LOAD) && !rst_int;
  assign accept   = s_tvalid && s_tready;
  assign room     = (wr_ptr_reg < CAP_LEN);
  assign commit   = (state_reg == ST_REQ) && cpu_grant && !rst_int;

  ros2_app_data_shadow #(
    .DATA_BYTES (DATA_BYTES),
    .ADDR_W     (ADDR_W)
  ) u_shadow (
    .clk_int (clk_int),
    .rst_int (rst_int),
    .wr_en   (accept && room),
    .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
    .wr_data (s_tdata),
    .clr     (state_reg == ST_REL),
    .rd_data (shadow_data)
  );

  // Frame assembly and arbiter handshake: LOAD bytes, REQ until granted, REL for one cycle.
  always_ff @(posedge clk_int) begin
    if (rst_int) begin
      state_reg  <= ST_LOAD;
      wr_ptr_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          if (accept) begin
            // Bytes past capacity are still accepted so the source never stalls.
            if (room) begin
              wr_ptr_reg <= wr_ptr_reg + LEN_WIDTH'(1);
            end else begin
              ovf_reg <= 1'b1;
            end
            if (s_tlast) begin
              state_reg <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (cpu_grant) begin
            state_reg <= ST_REL;
          end
        end
        ST_REL: begin
          wr_ptr_reg <= '0;
          ovf_reg    <= 1'b0;
          state_reg  <= ST_LOAD;
        end
        default: begin
          state_reg <= ST_LOAD;
        end
      endcase
    end
  end

  // Committed registers only move on the granted REQ cycle, so the core never sees a torn frame.
  always_ff @(posedge clk_int) begin
    if (rst_int) begin
      app_data_reg     <= '0;
      app_data_len_reg <= '0;
      commit_cnt_reg   <= 16'h0000;
    end else if (commit) begin
      app_data_reg     <= shadow_data;
      app_data_len_reg <= wr_ptr_reg + NUL_LEN;
      commit_cnt_reg   <= commit_cnt_reg + 16'h0001;
    end
  end

  assign app_data     = app_data_reg;
  assign app_data_len = app_data_len_reg;
  assign commit_cnt   = commit_cnt_reg;
  assign cpu_req      = (state_reg == ST_REQ);
  assign cpu_rel      = (state_reg == ST_REL);
  assign busy         = (state_reg != ST_LOAD);
  assign err_overflow = commit && ovf_reg;

endmodule

// File: tb/tb_ros2_app_data_writer.sv
// Self-checking bench for ros2_app_data_writer: table-driven frames, directed
// corner sequences and random frames checked against a byte-queue model.
module tb_ros2_app_data_writer;

  localparam int DB = 64;
  localparam int LW = 8;
`ifdef APP_DATA_NUL_TERM_EN
  localparam int NUL = 1;
`else
  localparam int NUL = 0;
`endif
  localparam int CAP = DB - NUL;

  logic            clk_int = 1'b0;
  logic            rst_int;
  logic [7:0]      s_tdata;
  logic            s_tvalid;
  logic            s_tready;
  logic            s_tlast;
  logic [8*DB-1:0] app_data;
  logic [LW-1:0]   app_data_len;
  logic            cpu_req;
  logic            cpu_grant;
  logic            cpu_rel;
  logic            busy;
  logic            err_overflow;
  logic [15:0]     commit_cnt;

  logic            arb_block;

  int              n_vec  = 0;
  int              n_miss = 0;
  logic [7:0]      pay[$];
  logic [511:0]    prev_data;
  int              exp_cnt;

  typedef struct {
    int n;
    int hold;
    int first;
    int exp_len;
    int exp_ovf;
  } vec_t;
  vec_t vt[6];

  ros2_app_data_writer #(.DATA_BYTES(DB), .LEN_WIDTH(LW)) dut (
    .clk_int      (clk_int),
    .rst_int      (rst_int),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tlast      (s_tlast),
    .app_data     (app_data),
    .app_data_len (app_data_len),
    .cpu_req      (cpu_req),
    .cpu_grant    (cpu_grant),
    .cpu_rel      (cpu_rel),
    .busy         (busy),
    .err_overflow (err_overflow),
    .commit_cnt   (commit_cnt)
  );

  always #5 clk_int = ~clk_int;

  // Arbiter model: registered grant following the request unless the IP side holds the buffer.
  always @(posedge clk_int) begin
    if (rst_int) cpu_grant <= 1'b0;
    else         cpu_grant <= cpu_req && !arb_block;
  end

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic send_bytes(input int max_gap, output int acc);
    int n;
    n = pay.size();
    acc = 0;
    for (int i = 0; i < n; i++) begin
      if (max_gap > 0) begin
        repeat ($urandom_range(max_gap, 0)) begin
          @(negedge clk_int);
          s_tvalid = 1'b0;
          s_tlast  = 1'b0;
        end
      end
      @(negedge clk_int);
      s_tvalid = 1'b1;
      s_tdata  = pay[i];
      s_tlast  = (i == n - 1);
      if (s_tready) acc++;
    end
    @(negedge clk_int);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Send the frame in pay, let the arbiter grant after hold cycles, check the commit.
  task automatic run_frame(input string tag, input int hold, input int max_gap,
                           output int got_len, output int got_ovf);
    int n, cap_n, acc, ovf_n, rel_n, rel_idx, bad_req, torn;
    bit seen_rel, done;
    logic [511:0] model;
    n = pay.size();
    cap_n = (n < CAP) ? n : CAP;
    model = '0;
    for (int i = 0; i < cap_n; i++) model[8*i +: 8] = pay[i];
    exp_cnt = (exp_cnt + 1) & 16'hFFFF;
    arb_block = (hold > 0);

    send_bytes(max_gap, acc);
    chk({tag, " req_after_last"}, {cpu_req, s_tready, busy}, 3'b101);

    seen_rel = 0; done = 0; rel_n = 0; rel_idx = -1;
    ovf_n = 0; bad_req = 0; torn = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk_int);
      if (err_overflow) ovf_n++;
      if (cpu_rel) begin
        rel_n++;
        if (!seen_rel) rel_idx = c;
        seen_rel = 1;
        if (cpu_req) bad_req++;
      end else if (seen_rel) begin
        done = 1;
      end else begin
        if (app_data !== prev_data) torn++;
        if (!cpu_req || s_tready) bad_req++;
      end
      if (c == hold - 1) arb_block = 1'b0;
    end
    arb_block = 1'b0;

    chk({tag, " completed"}, done, 1);
    chk({tag, " accepted"}, acc, n);
    chk({tag, " rel_latency"}, rel_idx, hold + 1);
    chk({tag, " rel_width"}, rel_n, 1);
    chk({tag, " req_hold"}, bad_req, 0);
    chk({tag, " no_tear"}, torn, 0);
    chk({tag, " data"}, app_data, model);
    chk({tag, " len"}, app_data_len, cap_n + NUL);
    chk({tag, " ovf_pulses"}, ovf_n, (n > CAP) ? 1 : 0);
    chk({tag, " commit_cnt"}, commit_cnt, exp_cnt);
    chk({tag, " back_to_load"}, {s_tready, busy}, 2'b10);
    prev_data = model;
    got_len = int'(app_data_len);
    got_ovf = ovf_n;
    $display("frame %s: bytes=%0d hold=%0d len=%0d ovf=%0d cnt=%0d",
             tag, n, hold, got_len, got_ovf, commit_cnt);
  endtask

  initial begin
    int l, o, acc;
    rst_int = 1'b1; arb_block = 1'b0;
    s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0;
    exp_cnt = 0; prev_data = '0;

`ifdef APP_DATA_NUL_TERM_EN
    vt[0] = '{n: 1,  hold: 0,   first: 8'h11, exp_len: 2,  exp_ovf: 0};
    vt[1] = '{n: 5,  hold: 3,   first: 8'h20, exp_len: 6,  exp_ovf: 0};
    vt[2] = '{n: 63, hold: 0,   first: 8'h01, exp_len: 64, exp_ovf: 0};
    vt[3] = '{n: 64, hold: 1,   first: 8'h80, exp_len: 64, exp_ovf: 1};
    vt[4] = '{n: 70, hold: 0,   first: 8'hA5, exp_len: 64, exp_ovf: 1};
    vt[5] = '{n: 10, hold: 100, first: 8'h3C, exp_len: 11, exp_ovf: 0};
`else
    vt[0] = '{n: 1,  hold: 0,   first: 8'h11, exp_len: 1,  exp_ovf: 0};
    vt[1] = '{n: 5,  hold: 3,   first: 8'h20, exp_len: 5,  exp_ovf: 0};
    vt[2] = '{n: 63, hold: 0,   first: 8'h01, exp_len: 63, exp_ovf: 0};
    vt[3] = '{n: 64, hold: 1,   first: 8'h80, exp_len: 64, exp_ovf: 0};
    vt[4] = '{n: 70, hold: 0,   first: 8'hA5, exp_len: 64, exp_ovf: 1};
    vt[5] = '{n: 10, hold: 100, first: 8'h3C, exp_len: 10, exp_ovf: 0};
`endif

    // Reset state
    repeat (3) @(negedge clk_int);
    chk("reset_ready", s_tready, 0);
    chk("reset_data", app_data, 0);
    chk("reset_len", app_data_len, 0);
    chk("reset_ctl", {cpu_req, cpu_rel, busy, err_overflow}, 4'b0000);
    chk("reset_cnt", commit_cnt, 0);
    rst_int = 1'b0;
    @(negedge clk_int);
    chk("post_reset_ready", s_tready, 1);

    // "hello" with an idle arbiter
    pay = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    run_frame("hello", 0, 0, l, o);
    chk("hello_bytes", app_data[39:0], 40'h6F6C6C6568);
    chk("hello_len", l, 5 + NUL);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      pay.delete();
      for (int i = 0; i < vt[v].n; i++) pay.push_back(8'((vt[v].first + 7 * i) & 8'hFF));
      run_frame($sformatf("tbl%0d", v), vt[v].hold, 0, l, o);
      chk($sformatf("tbl%0d exp_len", v), l, vt[v].exp_len);
      chk($sformatf("tbl%0d exp_ovf", v), o, vt[v].exp_ovf);
    end

    // Back-to-back "ab" then "c": stale 'b' must be cleared
    pay = '{8'h61, 8'h62};
    run_frame("ab", 0, 0, l, o);
    pay = '{8'h63};
    run_frame("c", 0, 0, l, o);
    chk("c_byte1_cleared", app_data[15:8], 8'h00);
    chk("c_len", l, 1 + NUL);

    // Random frames against the model
    for (int r = 0; r < 30; r++) begin
      int len;
      len = $urandom_range(80, 1);
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
      run_frame($sformatf("rnd%0d", r), $urandom_range(4, 0), 2, l, o);
    end

    // Reset while waiting in REQ
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    arb_block = 1'b1;
    send_bytes(0, acc);
    chk("rstreq_in_req", {cpu_req, s_tready}, 2'b10);
    repeat (3) @(negedge clk_int);
    rst_int = 1'b1;
    @(negedge clk_int);
    chk("rstreq_req_drop", {cpu_req, cpu_rel, busy, err_overflow}, 4'b0000);
    chk("rstreq_data", app_data, 0);
    chk("rstreq_len", app_data_len, 0);
    chk("rstreq_cnt", commit_cnt, 0);
    rst_int = 1'b0;
    arb_block = 1'b0;
    exp_cnt = 0;
    prev_data = '0;
    @(negedge clk_int);
    chk("rstreq_ready", s_tready, 1);
    $display("frame rst_in_req: bytes=4 reset applied cnt=%0d", commit_cnt);

    // Frames after reset start fresh
    for (int r = 0; r < 5; r++) begin
      int len;
      len = $urandom_range(70, 1);
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
      run_frame($sformatf("post%0d", r), $urandom_range(3, 0), 1, l, o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
